// File: rtl/sync_down_counter.sv
// Loadable synchronous down counter with one-shot / auto-reload terminal count,
// registered tc pulse and a sticky underflow flag.
module sync_down_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             uf_flag
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             uf_q, uf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      uf_q     <= uf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      // A zero load parks the counter in IDLE rather than starting a run.
      count_d  = load_val;
      reload_d = load_val;
      state_d  = (load_val != '0) ? StRun : StIdle;
    end else begin
      unique case (state_q)
        StRun: begin
          if (en) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
              tc_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = StDone;
              end
            end
          end
        end
        StDone: begin
          if (clr_flag) begin
            state_d = StIdle;
          end
        end
        default: ;
      endcase
    end

    // Set wins over clear when a terminal count coincides with clr_flag.
    uf_d = tc_d | (uf_q & ~clr_flag);
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign busy    = (state_q == StRun);
  assign uf_flag = uf_q;

endmodule

// File: tb/tb_sync_down_counter.sv
// Self-checking bench for sync_down_counter: directed vector table, async reset
// sequence and randomized stimulus against a behavioural model.
module tb_sync_down_counter;

  localparam int unsigned WIDTH = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic             clr_flag;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             uf_flag;

  int n_vec = 0;
  int n_bad = 0;

  sync_down_counter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (load_val),
    .en         (en),
    .auto_reload(auto_reload),
    .clr_flag   (clr_flag),
    .count      (count),
    .tc         (tc),
    .busy       (busy),
    .uf_flag    (uf_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ld;
    int   lv;
    logic e;
    logic ar;
    logic clr;
    int   x_count;
    logic x_tc;
    logic x_busy;
    logic x_uf;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int c, input logic t, input logic b,
                           input logic u);
    check({tag, ".count"}, int'(count), c);
    check({tag, ".tc"}, int'(tc), int'(t));
    check({tag, ".busy"}, int'(busy), int'(b));
    check({tag, ".uf_flag"}, int'(uf_flag), int'(u));
  endtask

  task automatic drive(input logic ld, input int lv, input logic e, input logic ar,
                       input logic clr);
    @(negedge clk);
    load        = ld;
    load_val    = WIDTH'(lv);
    en          = e;
    auto_reload = ar;
    clr_flag    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic ld, input int lv, input logic e, input logic ar, input logic clr,
                     input int c, input logic t, input logic b, input logic u);
    vec_t v;
    v = '{ld, lv, e, ar, clr, c, t, b, u};
    tbl.push_back(v);
  endtask

  // Behavioural model: mode 0 = idle, 1 = running, 2 = done.
  int   m_cnt, m_rel, m_mode;
  logic m_tc, m_uf;

  task automatic model_step(input logic ld, input int lv, input logic e, input logic ar,
                            input logic clr);
    m_tc = 1'b0;
    if (ld) begin
      m_cnt  = lv;
      m_rel  = lv;
      m_mode = (lv != 0) ? 1 : 0;
    end else if (m_mode == 1 && e) begin
      if (m_cnt == 1) begin
        m_tc = 1'b1;
        if (ar) m_cnt = m_rel;
        else begin
          m_cnt  = 0;
          m_mode = 2;
        end
      end else begin
        m_cnt = m_cnt - 1;
      end
    end else if (m_mode == 2 && clr) begin
      m_mode = 0;
    end
    if (m_tc) m_uf = 1'b1;
    else if (clr) m_uf = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0; clr_flag = 1'b0;
    #2;
    check_all("reset", 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    //  ld lv e ar clr  cnt tc busy uf
    // One-shot countdown from 5
    add(1, 5, 0, 0, 0,  5, 0, 1, 0);
    add(0, 0, 1, 0, 0,  4, 0, 1, 0);
    add(0, 0, 1, 0, 0,  3, 0, 1, 0);
    add(0, 0, 1, 0, 0,  2, 0, 1, 0);
    add(0, 0, 1, 0, 0,  1, 0, 1, 0);
    add(0, 0, 1, 0, 0,  0, 1, 0, 1);
    add(0, 0, 1, 0, 0,  0, 0, 0, 1);
    add(0, 0, 0, 0, 1,  0, 0, 0, 0);
    // Auto-reload from 3, tc coinciding with clr_flag keeps uf_flag set
    add(1, 3, 0, 1, 0,  3, 0, 1, 0);
    add(0, 0, 1, 1, 0,  2, 0, 1, 0);
    add(0, 0, 1, 1, 0,  1, 0, 1, 0);
    add(0, 0, 1, 1, 0,  3, 1, 1, 1);
    add(0, 0, 1, 1, 0,  2, 0, 1, 1);
    add(0, 0, 1, 1, 0,  1, 0, 1, 1);
    add(0, 0, 1, 1, 1,  3, 1, 1, 1);
    add(0, 0, 1, 1, 1,  2, 0, 1, 0);
    add(0, 0, 1, 0, 0,  1, 0, 1, 0);
    add(0, 0, 1, 0, 0,  0, 1, 0, 1);
    // Enable gating from 7
    add(1, 7, 0, 0, 0,  7, 0, 1, 1);
    add(0, 0, 1, 0, 0,  6, 0, 1, 1);
    add(0, 0, 0, 0, 0,  6, 0, 1, 1);
    add(0, 0, 0, 0, 0,  6, 0, 1, 1);
    add(0, 0, 1, 0, 0,  5, 0, 1, 1);
    // Load beats enable; zero load parks in IDLE
    add(0, 0, 1, 0, 0,  4, 0, 1, 1);
    add(0, 0, 1, 0, 0,  3, 0, 1, 1);
    add(0, 0, 1, 0, 0,  2, 0, 1, 1);
    add(1, 4, 1, 0, 0,  4, 0, 1, 1);
    add(1, 0, 1, 0, 0,  0, 0, 0, 1);
    add(0, 0, 1, 1, 0,  0, 0, 0, 1);
    add(0, 0, 0, 0, 1,  0, 0, 0, 0);
    // auto_reload only matters in the count==1 cycle
    add(1, 2, 0, 1, 0,  2, 0, 1, 0);
    add(0, 0, 1, 1, 0,  1, 0, 1, 0);
    add(0, 0, 1, 0, 0,  0, 1, 0, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].ld, tbl[i].lv, tbl[i].e, tbl[i].ar, tbl[i].clr);
      check_all($sformatf("vec%0d", i), tbl[i].x_count, tbl[i].x_tc, tbl[i].x_busy, tbl[i].x_uf);
    end

    // Async reset mid-count aborts the run with no later tc
    drive(1, 5, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    check_all("pre_rst", 3, 1'b0, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 1, 1, 0);
      check_all($sformatf("post_rst%0d", k), 0, 1'b0, 1'b0, 1'b0);
    end

    // Randomized run against the model, starting from the post-reset idle state
    m_cnt = 0; m_rel = 0; m_mode = 0; m_tc = 1'b0; m_uf = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      logic ld, e, ar, clr;
      int   lv;
      ld  = ($urandom_range(0, 5) == 0);
      lv  = $urandom_range(0, (1 << WIDTH) - 1);
      e   = ($urandom_range(0, 3) != 0);
      ar  = $urandom_range(0, 1);
      clr = ld ? 1'b0 : ($urandom_range(0, 7) == 0);
      drive(ld, lv, e, ar, clr);
      model_step(ld, lv, e, ar, clr);
      check_all($sformatf("rnd%0d", k), m_cnt, m_tc, (m_mode == 1), m_uf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_down_counter.md
SYNC_DOWN_COUNTER -- requirements
Module: sync_down_counter

Interface
REQ-001 Parameter: WIDTH, default 3, counter width in bits (WIDTH >= 2).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 load  input  1  load/restart request, sampled at posedge clk.
REQ-005 load_val  input  WIDTH  start/reload value captured on load.
REQ-006 en  input  1  count enable; 0 freezes count and state.
REQ-007 auto_reload  input  1  1 = reload on terminal count; 0 = one-shot.
REQ-008 clr_flag  input  1  clears uf_flag and leaves DONE.
REQ-009 count  output  WIDTH  current count value (registered).
REQ-010 tc  output  1  terminal-count pulse, registered, one clk wide.
REQ-011 busy  output  1  high while in state RUN.
REQ-012 uf_flag  output  1  sticky underflow flag, set on every tc.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, DONE; busy = (state == RUN), combinational from the state register.
REQ-014 The block SHALL hold an internal WIDTH-bit reload register, written only on accepted load.
REQ-015 load=1 with load_val != 0, in any state, SHALL set count=load_val and reload register=load_val, go to RUN next cycle, regardless of en; load has priority over en and clr_flag.
REQ-016 load=1 with load_val == 0 SHALL set count=0 and reload register=0, go to IDLE, assert no tc.
REQ-017 In RUN with en=1, load=0 and count > 1, count SHALL decrement by 1 per cycle.
REQ-018 In RUN with en=1, load=0 and count == 1: if auto_reload=1, count SHALL become reload register value and state stays RUN; else count SHALL become 0 and state goes to DONE.
REQ-019 tc SHALL be 1 in exactly the cycle following the REQ-018 decrement (registered alongside count) and 0 in all other cycles.
REQ-020 auto_reload SHALL be sampled at the count==1 cycle only; changing it earlier has no effect on the count.
REQ-021 In RUN with en=0, count, state and reload register SHALL hold; tc SHALL be 0.
REQ-022 In IDLE and DONE, count SHALL hold and en SHALL be ignored.
REQ-023 In DONE, clr_flag=1 (with load=0) SHALL move state to IDLE; count stays 0.
REQ-024 uf_flag SHALL set on the same edge that asserts tc and clear on clr_flag=1; simultaneous set and clear SHALL leave uf_flag=1.
REQ-025 clr_flag in IDLE or RUN SHALL clear uf_flag only, with no effect on state or count.
REQ-026 Count arithmetic SHALL be unsigned modulo 2^WIDTH; count SHALL never wrap below 0 (terminal condition is count==1, not 0).

Reset
REQ-027 rst=1 SHALL immediately, without a clock edge, force state=IDLE, count=0, reload register=0, tc=0, uf_flag=0, busy=0.
REQ-028 Reset asserted mid-count SHALL abort the count; no tc SHALL be produced for the aborted sequence.
REQ-029 After rst deasserts, the first accepted load SHALL behave per REQ-015/016.

Verification
REQ-030 WIDTH=3, load_val=5, en=1, auto_reload=0: count 5,4,3,2,1,0 on successive cycles; tc=1 only when count=0; busy falls, uf_flag=1, state DONE.
REQ-031 load_val=3, auto_reload=1, en=1 for 9 cycles: count 3,2,1,3,2,1,3,2,1; tc pulses each time count returns to 3; busy stays 1.
REQ-032 load_val=7, toggle en 1,0,0,1: count 7,6,6,6,5; no tc; busy=1 throughout.
REQ-033 Count at 2, load with load_val=4 and en=1 same cycle: next count=4 (load wins), no tc; load_val=0: count=0, IDLE, busy=0, no tc.
REQ-034 In DONE with uf_flag=1: clr_flag=1 -> uf_flag=0, IDLE; auto-reload tc coinciding with clr_flag -> uf_flag remains 1.
REQ-035 rst pulsed asynchronously between edges while count=3 in RUN: count=0, busy=0, uf_flag=0 immediately; no tc afterwards until new load.
